spin_sequencer: RTL and testbench
=================================

# spin_sequencer

Motor-side responder to the cube-scanning FSM in `determine_state`. Each one-cycle `send_setup_moves` pulse carries a step index on `counter`. For each pulse, the block expands the step into that step's fixed list of face turns and issues the turns one at a time to the motor driver over a start/done handshake. After the last turn it waits a settle interval and then pulses `color_sensor_stable` so the scanner can sample the next sticker.

## Interface
- `SETTLE_CYCLES`, default 2_000_000: cycles between the last `motor_done` (or request acceptance, for an empty list) and the `color_sensor_stable` pulse; must be ≥1.
- `SETTLE_W`, default 24: width of the settle counter; must hold `SETTLE_CYCLES`.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `send_setup_moves`  in  1  one-cycle step request.
- `counter`  in  6  step index s, sampled when `send_setup_moves`=1.
- `motor_done`  in  1  one-cycle pulse: the current turn has finished.
- `move_start`  out  1  one-cycle pulse: begin turn `move_code`.
- `move_code`  out  5  {face[2:0], turn[1:0]}.
  - Face: U=0, L=1, F=2, R=3, B=4, D=5.
  - Turn: 01 = CW, 10 = half, 11 = CCW (prime).
- `color_sensor_stable`  out  1  one-cycle pulse: cube settled, sensors valid.
- `busy`  out  1  high from request acceptance through the `color_sensor_stable` pulse cycle.
- `request_dropped`  out  1  sticky; set when a request arrives while `busy`=1. Cleared only by reset.

## Operation
**Move list for step s (0..48)** is the concatenation, in this order:
1. U, if s>0.
2. exit(batch (s−1)/4), if s>0 and s%4==0.
3. entry(batch s/4), if s<48 and s%4==0.

**Batch table (entry / exit):**
- 0: none / none
- 1: F B' L U F B' / B F' U' L' B F'
- 2: L' R F U' L' R / R' L U F' R' L
- 3: F' B R U F' B / B' F U' R' B' F
- 4: L R' B' U L R' / R L' U' B R L'
- 5: R2 L2 F2 B2 / B2 F2 L2 R2
- 6: none / none
- 7: F B' / B F'
- 8: L' R / R' L
- 9: F' B / B' F
- 10: L R' / R L'
- 11: L2 R2 / L2 R2

**List-length rules:**
- Maximum list length is 13.
- Step 48 (the final restore) is the list U L2 R2 and still ends with a `color_sensor_stable` pulse.
- Steps 49..63 produce an empty list.

**FSM states:** IDLE, ISSUE, WAIT_DONE, SETTLE, REPORT.
- IDLE: on `send_setup_moves`, latch s and zero the move pointer.
  - Go to ISSUE if the list is non-empty, else go to SETTLE.
- ISSUE: assert `move_start` with `move_code` = list[ptr]; go to WAIT_DONE.
- WAIT_DONE: on `motor_done`, increment ptr.
  - Go to ISSUE if ptr < length, else go to SETTLE with the settle counter cleared.
- SETTLE: count up to SETTLE_CYCLES−1, then go to REPORT.
- REPORT: assert `color_sensor_stable` for one cycle; go to IDLE.

**Input edge cases:**
- `motor_done` outside WAIT_DONE is ignored.
- Requests received while not in IDLE are ignored and set `request_dropped`.

## Timing
- Reset values: `move_start`=0, `move_code`=0, `color_sensor_stable`=0, `busy`=0, `request_dropped`=0, FSM in IDLE.
- Request sampled in cycle t → `busy`=1 from t+1.
  - Non-empty list: first `move_start` at t+1.
  - Empty list: SETTLE starts at t+1.
- `motor_done` in cycle d → next `move_start` at d+1, or SETTLE begins at d+1 after the last turn.
- `move_code` holds its value from `move_start` until the next `move_start`.
- `color_sensor_stable` fires exactly SETTLE_CYCLES cycles after SETTLE entry, in the REPORT cycle. `busy` falls the following cycle.
- A new request is accepted in the cycle immediately after REPORT.
- `motor_done` coincident with `move_start` (same cycle) is ignored.
- Reset mid-operation (any state) returns to IDLE immediately. No `color_sensor_stable` pulse is emitted and the move pointer is discarded.

## Test plan
- s=0, SETTLE_CYCLES=4: no `move_start` → `color_sensor_stable` pulse 5 cycles after the request, `busy` 5 cycles.
- s=4, motor_done 3 cycles after each start → 7 starts with codes 0x01, 0x09, 0x13, 0x05, 0x01, 0x09, 0x13, then the stable pulse.
- s=24 → codes 0x01, 0x12, 0x0A, 0x06, 0x0E; s=48 → 0x01, 0x06, 0x0E, then the stable pulse.
- Request while busy → ignored, `request_dropped`=1 and remains 1; current list completes unchanged.
- Reset asserted during WAIT_DONE → all outputs 0 asynchronously; next request s=1 yields a single 0x01 turn.
- Spurious `motor_done` during SETTLE/IDLE → no pointer change, no extra `move_start`.

Source files
------------

// File: rtl/spin_sequencer.sv
// Motor-side step sequencer: expands a scan step index into its face-turn list,
// issues the turns over a start/done handshake, then settles and reports.
`timescale 1ns/1ps
module spin_sequencer #(
  parameter int SETTLE_CYCLES = 2_000_000,
  parameter int SETTLE_W      = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send_setup_moves,
  input  logic [5:0] counter,
  input  logic       motor_done,
  output logic       move_start,
  output logic [4:0] move_code,
  output logic       color_sensor_stable,
  output logic       busy,
  output logic       request_dropped
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, SETTLE, REPORT} state_e;

  localparam logic [4:0] MV_U  = 5'h01, MV_UP = 5'h03;
  localparam logic [4:0] MV_L  = 5'h05, MV_L2 = 5'h06, MV_LP = 5'h07;
  localparam logic [4:0] MV_F  = 5'h09, MV_F2 = 5'h0A, MV_FP = 5'h0B;
  localparam logic [4:0] MV_R  = 5'h0D, MV_R2 = 5'h0E, MV_RP = 5'h0F;
  localparam logic [4:0] MV_B  = 5'h11, MV_B2 = 5'h12, MV_BP = 5'h13;

  // Batch rows hold up to six turns, first turn in the most significant slot.
  function automatic logic [29:0] entryRow(input logic [3:0] b);
    case (b)
      4'd1:    return {MV_F, MV_BP, MV_L, MV_U, MV_F, MV_BP};
      4'd2:    return {MV_LP, MV_R, MV_F, MV_UP, MV_LP, MV_R};
      4'd3:    return {MV_FP, MV_B, MV_R, MV_U, MV_FP, MV_B};
      4'd4:    return {MV_L, MV_RP, MV_BP, MV_U, MV_L, MV_RP};
      4'd5:    return {MV_R2, MV_L2, MV_F2, MV_B2, 10'd0};
      4'd7:    return {MV_F, MV_BP, 20'd0};
      4'd8:    return {MV_LP, MV_R, 20'd0};
      4'd9:    return {MV_FP, MV_B, 20'd0};
      4'd10:   return {MV_L, MV_RP, 20'd0};
      4'd11:   return {MV_L2, MV_R2, 20'd0};
      default: return 30'd0;
    endcase
  endfunction

  function automatic logic [29:0] exitRow(input logic [3:0] b);
    case (b)
      4'd1:    return {MV_B, MV_FP, MV_UP, MV_LP, MV_B, MV_FP};
      4'd2:    return {MV_RP, MV_L, MV_U, MV_FP, MV_RP, MV_L};
      4'd3:    return {MV_BP, MV_F, MV_UP, MV_RP, MV_BP, MV_F};
      4'd4:    return {MV_R, MV_LP, MV_UP, MV_B, MV_R, MV_LP};
      4'd5:    return {MV_B2, MV_F2, MV_L2, MV_R2, 10'd0};
      4'd7:    return {MV_B, MV_FP, 20'd0};
      4'd8:    return {MV_RP, MV_L, 20'd0};
      4'd9:    return {MV_BP, MV_F, 20'd0};
      4'd10:   return {MV_R, MV_LP, 20'd0};
      4'd11:   return {MV_L2, MV_R2, 20'd0};
      default: return 30'd0;
    endcase
  endfunction

  function automatic logic [3:0] batchLen(input logic [3:0] b);
    case (b)
      4'd1, 4'd2, 4'd3, 4'd4:         return 4'd6;
      4'd5:                           return 4'd4;
      4'd7, 4'd8, 4'd9, 4'd10, 4'd11: return 4'd2;
      default:                        return 4'd0;
    endcase
  endfunction

  function automatic logic [4:0] pick(input logic [29:0] row, input logic [2:0] i);
    logic [29:0] sh;
    sh = row << (5 * i);
    return sh[29:25];
  endfunction

  function automatic logic hasU(input logic [5:0] s);
    return (s != 6'd0) && (s <= 6'd48);
  endfunction

  function automatic logic exitOn(input logic [5:0] s);
    return (s != 6'd0) && (s[1:0] == 2'b00) && (s <= 6'd48);
  endfunction

  function automatic logic entryOn(input logic [5:0] s);
    return (s < 6'd48) && (s[1:0] == 2'b00);
  endfunction

  function automatic logic [3:0] listLen(input logic [5:0] s);
    logic [3:0] n;
    n = {3'b000, hasU(s)};
    if (exitOn(s))  n = n + batchLen(s[5:2] - 4'd1);
    if (entryOn(s)) n = n + batchLen(s[5:2]);
    return n;
  endfunction

  // List order: optional U, then the previous batch's exit, then this batch's entry.
  function automatic logic [4:0] listMove(input logic [5:0] s, input logic [3:0] p);
    logic [3:0] q;
    logic [3:0] exitLen;
    logic [3:0] r;
    q       = p - {3'b000, hasU(s)};
    exitLen = exitOn(s) ? batchLen(s[5:2] - 4'd1) : 4'd0;
    r       = q - exitLen;
    if (hasU(s) && (p == 4'd0)) return MV_U;
    else if (q < exitLen)       return pick(exitRow(s[5:2] - 4'd1), q[2:0]);
    else if (entryOn(s))        return pick(entryRow(s[5:2]), r[2:0]);
    else                        return 5'd0;
  endfunction

  state_e              state_q, state_d;
  logic [5:0]          step_q, step_d;
  logic [3:0]          ptr_q, ptr_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [4:0]          code_q, code_d;
  logic                dropped_q, dropped_d;
  logic [4:0]          curCode;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      step_q    <= 6'd0;
      ptr_q     <= 4'd0;
      cnt_q     <= '0;
      code_q    <= 5'd0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      dropped_q <= dropped_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    step_d              = step_q;
    ptr_d               = ptr_q;
    cnt_d               = cnt_q;
    code_d              = code_q;
    dropped_d           = dropped_q | (send_setup_moves && (state_q != IDLE));
    curCode             = listMove(step_q, ptr_q);
    move_start          = 1'b0;
    color_sensor_stable = 1'b0;
    case (state_q)
      IDLE: begin
        if (send_setup_moves) begin
          step_d  = counter;
          ptr_d   = 4'd0;
          cnt_d   = '0;
          state_d = (listLen(counter) != 4'd0) ? ISSUE : SETTLE;
        end
      end
      ISSUE: begin
        move_start = 1'b1;
        code_d     = curCode;
        state_d    = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (motor_done) begin
          ptr_d = ptr_q + 4'd1;
          cnt_d = '0;
          state_d = ((ptr_q + 4'd1) < listLen(step_q)) ? ISSUE : SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_W'(SETTLE_CYCLES - 1)) state_d = REPORT;
        else                                       cnt_d   = cnt_q + 1'b1;
      end
      REPORT: begin
        color_sensor_stable = 1'b1;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The code is presented live during ISSUE and held from the register afterwards.
  assign move_code       = (state_q == ISSUE) ? curCode : code_q;
  assign busy            = (state_q != IDLE);
  assign request_dropped = dropped_q;

endmodule

// File: tb/tb_spin_sequencer.sv
// Bench for spin_sequencer: a string-based move-list model feeds a scoreboard queue
// that is drained as the DUT issues turns; settle latency and busy width are checked too.
`timescale 1ns/1ps
module tb_spin_sequencer;

  localparam int SC = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       send_setup_moves = 1'b0;
  logic [5:0] counter = 6'd0;
  logic       motor_done = 1'b0;
  logic       move_start;
  logic [4:0] move_code;
  logic       color_sensor_stable;
  logic       busy;
  logic       request_dropped;

  int checks = 0;
  int failures = 0;
  logic [4:0] expQ[$];

  typedef struct {
    int s;
    int k;
    int expStarts;
  } vec_t;

  vec_t vecs[11];

  spin_sequencer #(.SETTLE_CYCLES(SC), .SETTLE_W(3)) dut (
    .clock(clock),
    .reset(reset),
    .send_setup_moves(send_setup_moves),
    .counter(counter),
    .motor_done(motor_done),
    .move_start(move_start),
    .move_code(move_code),
    .color_sensor_stable(color_sensor_stable),
    .busy(busy),
    .request_dropped(request_dropped)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  function automatic string entryStr(input int b);
    case (b)
      1: return "F B' L U F B'";
      2: return "L' R F U' L' R";
      3: return "F' B R U F' B";
      4: return "L R' B' U L R'";
      5: return "R2 L2 F2 B2";
      7: return "F B'";
      8: return "L' R";
      9: return "F' B";
      10: return "L R'";
      11: return "L2 R2";
      default: return "";
    endcase
  endfunction

  function automatic string exitStr(input int b);
    case (b)
      1: return "B F' U' L' B F'";
      2: return "R' L U F' R' L";
      3: return "B' F U' R' B' F";
      4: return "R L' U' B R L'";
      5: return "B2 F2 L2 R2";
      7: return "B F'";
      8: return "R' L";
      9: return "B' F";
      10: return "R L'";
      11: return "L2 R2";
      default: return "";
    endcase
  endfunction

  task automatic pushMoves(input string seq);
    int face;
    int turn;
    byte c;
    for (int i = 0; i < seq.len(); i++) begin
      c = seq.getc(i);
      face = -1;
      case (c)
        "U": face = 0;
        "L": face = 1;
        "F": face = 2;
        "R": face = 3;
        "B": face = 4;
        "D": face = 5;
        default: face = -1;
      endcase
      if (face >= 0) begin
        turn = 1;
        if (i + 1 < seq.len()) begin
          if (seq.getc(i + 1) == "'") turn = 3;
          else if (seq.getc(i + 1) == "2") turn = 2;
        end
        expQ.push_back(5'(face * 4 + turn));
      end
    end
  endtask

  task automatic pushStep(input int s);
    if (s > 0 && s <= 48) pushMoves("U");
    if (s > 0 && s <= 48 && s % 4 == 0) pushMoves(exitStr((s - 1) / 4));
    if (s < 48 && s % 4 == 0) pushMoves(entryStr(s / 4));
  endtask

  // One full request: cycle 0 carries the request; motor_done answers k cycles after each start.
  task automatic applyStimulus(input int s, input int k, input int expStarts,
                               input int dropAt, input bit spur);
    int starts = 0;
    int doneAt = -1;
    int lastDone = 0;
    int busyCnt = 0;
    int stableCyc = -1;
    bit finished = 0;
    logic [4:0] exp;
    pushStep(s);
    @(negedge clock);
    send_setup_moves = 1'b1;
    counter = 6'(s);
    motor_done = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clock);
      send_setup_moves = 1'b0;
      motor_done = 1'b0;
      if (busy) busyCnt++;
      if (stableCyc >= 0) begin
        checkOutput("busy_after_report", int'(busy), 0);
        finished = 1;
      end
      if (move_start) begin
        starts++;
        if (expQ.size() == 0) begin
          checkOutput("extra_move_start", 1, 0);
        end else begin
          exp = expQ.pop_front();
          checkOutput($sformatf("move_code s=%0d n=%0d", s, starts), int'(move_code), int'(exp));
        end
        doneAt = cyc + k;
      end
      if (color_sensor_stable && stableCyc < 0) begin
        stableCyc = cyc;
        checkOutput("pending_moves_at_stable", expQ.size(), 0);
      end
      if (cyc == doneAt) begin
        motor_done = 1'b1;
        lastDone = cyc;
      end
      if (spur && lastDone > 0 && lastDone == doneAt && expQ.size() == 0 && cyc == lastDone + 2)
        motor_done = 1'b1;
      if (cyc == dropAt) begin
        send_setup_moves = 1'b1;
        counter = 6'd8;
      end
      if (finished) break;
    end
    if (!finished) checkOutput("timeout_waiting_stable", 0, 1);
    checkOutput($sformatf("starts s=%0d", s), starts, expStarts);
    checkOutput($sformatf("stable_latency s=%0d", s), stableCyc, expStarts * (k + 1) + SC + 1);
    checkOutput($sformatf("busy_cycles s=%0d", s), busyCnt, expStarts * (k + 1) + SC + 1);
    expQ.delete();
  endtask

  initial begin
    vecs[0]  = '{0, 3, 0};
    vecs[1]  = '{1, 3, 1};
    vecs[2]  = '{4, 3, 7};
    vecs[3]  = '{8, 1, 13};
    vecs[4]  = '{24, 3, 5};
    vecs[5]  = '{28, 2, 3};
    vecs[6]  = '{44, 1, 5};
    vecs[7]  = '{48, 3, 3};
    vecs[8]  = '{50, 3, 0};
    vecs[9]  = '{5, 1, 1};
    vecs[10] = '{20, 2, 11};

    repeat (2) @(negedge clock);
    checkOutput("reset_move_start", int'(move_start), 0);
    checkOutput("reset_move_code", int'(move_code), 0);
    checkOutput("reset_stable", int'(color_sensor_stable), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_dropped", int'(request_dropped), 0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++)
      applyStimulus(vecs[i].s, vecs[i].k, vecs[i].expStarts, 0, 1'b0);
    checkOutput("dropped_clear_after_table", int'(request_dropped), 0);

    applyStimulus(4, 3, 7, 2, 1'b0);
    checkOutput("dropped_set", int'(request_dropped), 1);

    applyStimulus(24, 3, 5, 0, 1'b1);
    checkOutput("dropped_sticky", int'(request_dropped), 1);

    @(negedge clock);
    motor_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      motor_done = 1'b0;
      checkOutput("idle_spurious_start", int'(move_start), 0);
      checkOutput("idle_spurious_busy", int'(busy), 0);
    end

    @(negedge clock);
    send_setup_moves = 1'b1;
    counter = 6'd4;
    @(negedge clock);
    send_setup_moves = 1'b0;
    checkOutput("pre_reset_start", int'(move_start), 1);
    checkOutput("pre_reset_code", int'(move_code), 5'h01);
    @(negedge clock);
    checkOutput("pre_reset_code_held", int'(move_code), 5'h01);
    checkOutput("pre_reset_busy", int'(busy), 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_move_start", int'(move_start), 0);
    checkOutput("async_reset_move_code", int'(move_code), 0);
    checkOutput("async_reset_stable", int'(color_sensor_stable), 0);
    checkOutput("async_reset_busy", int'(busy), 0);
    checkOutput("async_reset_dropped", int'(request_dropped), 0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1, 3, 1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
